index_frame_reader: RTL

Scan-out engine for the 3-bit index frame buffer that the typer/draw path writes. It generates 640x480 VGA timing and issues sequential read addresses to the buffer's read port. It maps each returned 3-bit index through an 8-entry RGB palette and drives pipeline-aligned pixel, sync and blank outputs to the DAC. It sits between the dual-port index memory and the VGA connector, and exports a frame-start pulse so writers can schedule updates.

---
 rtl/index_frame_reader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/index_frame_reader.sv
// rtl/index_frame_reader.sv - VGA scan-out of a 3-bit index frame buffer through an 8-entry RGB palette
module index_frame_reader #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int MEM_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    output logic [18:0] mem_raddr,
    input  logic [2:0]  mem_rdata,
    input  logic        pal_we,
    input  logic [2:0]  pal_waddr,
    input  logic [23:0] pal_wdata,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_blank_n,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int L       = MEM_LATENCY + 1;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [18:0]   addr_cnt;
    logic          h_last;
    logic          v_last;
    logic          active;
    logic          hsync_raw;
    logic          vsync_raw;

    // Delay lines: bit k holds the timing flag of the position k+1 clocks ago
    logic [L-1:0]  act_sr;
    logic [L-1:0]  hs_sr;
    logic [L-1:0]  vs_sr;

    logic [23:0]   pal [8];
    logic [23:0]   rgb_q;

    // Undelayed raster decode of the current counter position
    always_comb begin
        h_last    = (h_cnt == H_LAST);
        v_last    = (v_cnt == V_LAST);
        active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hsync_raw = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
        vsync_raw = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
    end

    // Raster counters and the incremental read address (restarts at each frame wrap)
    always_ff @(posedge clock) begin
        if (reset) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            addr_cnt <= '0;
        end else begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
            if (h_last && v_last) begin
                addr_cnt <= '0;
            end else if (active) begin
                addr_cnt <= addr_cnt + 19'd1;
            end
        end
    end

    // Carry blank/sync through the same latency as the memory plus palette path
    always_ff @(posedge clock) begin
        if (reset) begin
            act_sr <= '0;
            hs_sr  <= '1;
            vs_sr  <= '1;
        end else begin
            act_sr <= {act_sr[L-2:0], active};
            hs_sr  <= {hs_sr[L-2:0], hsync_raw};
            vs_sr  <= {vs_sr[L-2:0], vsync_raw};
        end
    end

    // Palette registers; a write lands at the clock edge so a same-clock lookup sees the old entry
    always_ff @(posedge clock) begin
        if (reset) begin
            pal[0] <= 24'h000000;
            pal[1] <= 24'hFFFFFF;
            pal[2] <= 24'hFF0000;
            pal[3] <= 24'h00FF00;
            pal[4] <= 24'h0000FF;
            pal[5] <= 24'hFFFF00;
            pal[6] <= 24'h00FFFF;
            pal[7] <= 24'hFF00FF;
        end else if (pal_we) begin
            pal[pal_waddr] <= pal_wdata;
        end
    end

    // Registered palette lookup; stage MEM_LATENCY-1 is the active flag aligned with mem_rdata
    always_ff @(posedge clock) begin
        if (reset) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= act_sr[MEM_LATENCY-1] ? pal[mem_rdata] : 24'h000000;
        end
    end

    assign mem_raddr   = addr_cnt;
    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];
    assign vga_blank_n = act_sr[L-1];
    assign vga_hsync   = hs_sr[L-1];
    assign vga_vsync   = vs_sr[L-1];
    assign frame_start = !reset && (h_cnt == '0) && (v_cnt == '0);

endmodule
